alu_sequencer: RTL

Instruction-issuing front end for the 4-bit combinational ALU. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 4×4-bit register file. It drives opcode and operands to the external ALU, captures the ALU result, writes it back and presents it on a valid/ready result port. It is the initiator that sits between the test/control logic and the ALU, owning all operand storage and sequencing.

---
 rtl/alu_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Single-issue front end for the 4-bit ALU: accepts an instruction, reads RF operands, writes back the ALU result.
// Latency 2 cycles accept-to-result; in_ready stays low until the result handshake, so res_ready stalls new issue but not writeback.
// Optional ALU_SEQ_DIVZ_CHECK_EN: DIV by zero suppresses writeback, returns 4'hF and raises err for the response.
module alu_sequencer #(
   parameter logic [3:0] RF_INIT = 4'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [11:0] in_instr,
   output logic [2:0]  alu_oc,
   output logic [3:0]  alu_a,
   output logic [3:0]  alu_b,
   input  logic [3:0]  alu_f,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [3:0]  res_data,
   output logic [1:0]  res_rd,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [2:0] OC_DIV = 3'b011;

   state_t      state;
   state_t      state_nxt;
   logic        ld_q;
   logic [1:0]  rd_q;
   logic [3:0]  imm_q;
   logic [3:0]  rf [4];
   logic        accept;
   logic        divz;
   logic        wb_en;
   logic [3:0]  result;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (in_valid) state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_RESP;
         S_RESP:  if (res_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b1;
      if (state == S_IDLE) begin
         in_ready = 1'b1;
         busy     = 1'b0;
      end
   end

   assign accept = in_valid & in_ready;

`ifdef ALU_SEQ_DIVZ_CHECK_EN
   assign divz = !ld_q && (alu_oc == OC_DIV) && (alu_b == 4'h0);
`else
   assign divz = 1'b0;
`endif

   assign result = ld_q ? imm_q : (divz ? 4'hF : alu_f);
   assign wb_en  = (state == S_EXEC) && !divz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_q      <= 1'b0;
         rd_q      <= 2'd0;
         imm_q     <= 4'h0;
         alu_oc    <= 3'd0;
         alu_a     <= 4'h0;
         alu_b     <= 4'h0;
         res_valid <= 1'b0;
         res_data  <= 4'h0;
         res_rd    <= 2'd0;
         for (int i = 0; i < 4; i++) begin
            rf[i] <= RF_INIT;
         end
      end else begin
         // ALU drive registers update only on accept, so they hold outside EXEC
         if (accept) begin
            ld_q   <= in_instr[11];
            rd_q   <= in_instr[7:6];
            imm_q  <= in_instr[3:0];
            alu_oc <= in_instr[10:8];
            alu_a  <= rf[in_instr[5:4]];
            alu_b  <= rf[in_instr[3:2]];
         end
         if (state == S_EXEC) begin
            res_data  <= result;
            res_rd    <= rd_q;
            res_valid <= 1'b1;
         end else if ((state == S_RESP) && res_ready) begin
            res_valid <= 1'b0;
         end
         if (wb_en) begin
            rf[rd_q] <= result;
         end
      end
   end

`ifdef ALU_SEQ_DIVZ_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (state == S_EXEC) begin
         err <= divz;
      end else if ((state == S_RESP) && res_ready) begin
         err <= 1'b0;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule
